data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one combinational-read data memory between the CPU
// load/store port (port 0) and a secondary requester (port 1). Ties are broken
// round-robin. A port can keep ownership for a bounded number of cycles with
// its lock input. Load data comes back one cycle after the grant.
module data_mem_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int MAX_HOLD      = 16
) (
   input  logic                     clk,
   input  logic                     rst,

   input  logic                     req0,
   input  logic                     we0,
   input  logic                     mode0,
   input  logic                     lock0,
   input  logic [ADDRESS_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0]    wdata0,
   output logic                     gnt0,
   output logic                     rvalid0,
   output logic [DATA_WIDTH-1:0]    rdata0,

   input  logic                     req1,
   input  logic                     we1,
   input  logic                     mode1,
   input  logic                     lock1,
   input  logic [ADDRESS_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0]    wdata1,
   output logic                     gnt1,
   output logic                     rvalid1,
   output logic [DATA_WIDTH-1:0]    rdata1,

   output logic                     mem_we,
   output logic                     mem_mode,
   output logic [ADDRESS_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0]    mem_wd,
   input  logic [DATA_WIDTH-1:0]    mem_rd
);

   // The counter must be able to hold MAX_HOLD itself without wrapping.
   localparam int CNT_W = $clog2(MAX_HOLD) + 1;

   // Counter value seen during the last owned cycle; leaving at that edge
   // gives the owner exactly MAX_HOLD consecutive grant opportunities,
   // counting the IDLE cycle in which it first won.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   // With MAX_HOLD of 1 the winning cycle already uses the whole allowance,
   // so the owned states are never entered.
   localparam bit CAN_LOCK = (MAX_HOLD > 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    last_q, last_d;
   logic                    rvalid0_q, rvalid0_d;
   logic                    rvalid1_q, rvalid1_d;
   logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
   logic                    grant0;
   logic                    grant1;

   // Grant decision: nothing is granted while reset is held; in IDLE a lone
   // request wins and a tie goes to the port that did not win last time
   // (last_q = 1 means port 1 won last); an owned state only serves its owner.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (req0 && req1) begin
                  grant0 = last_q;
                  grant1 = !last_q;
               end else begin
                  grant0 = req0;
                  grant1 = req1;
               end
            end
            OWN0:    grant0 = req0;
            OWN1:    grant1 = req1;
            default: begin
               grant0 = 1'b0;
               grant1 = 1'b0;
            end
         endcase
      end
   end

   assign gnt0 = grant0;
   assign gnt1 = grant1;

   // Memory request mux: the granted port's request goes straight to the
   // memory; with no grant every memory output is driven to zero.
   always_comb begin
      mem_we   = 1'b0;
      mem_mode = 1'b0;
      mem_a    = '0;
      mem_wd   = '0;
      if (grant0) begin
         mem_we   = we0;
         mem_mode = mode0;
         mem_a    = addr0;
         mem_wd   = wdata0;
      end else if (grant1) begin
         mem_we   = we1;
         mem_mode = mode1;
         mem_a    = addr1;
         mem_wd   = wdata1;
      end
   end

   // Ownership FSM next state: the winner pointer follows every grant, a
   // locked IDLE win enters the owned state with the counter at 1, and the
   // owned state counts every cycle (granted or not) until lock drops or the
   // hold limit is reached. Leaving points the winner at the owner so the
   // other port takes the next tie.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;

      if (grant0) begin
         last_d = 1'b0;
      end else if (grant1) begin
         last_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (CAN_LOCK && grant0 && lock0) begin
               state_d = OWN0;
               cnt_d   = CNT_W'(1);
            end else if (CAN_LOCK && grant1 && lock1) begin
               state_d = OWN1;
               cnt_d   = CNT_W'(1);
            end
         end
         OWN0: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!lock0 || (cnt_q >= HOLD_LAST)) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end
         end
         OWN1: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!lock1 || (cnt_q >= HOLD_LAST)) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Load return path: a granted load captures the memory read data at the
   // end of its grant cycle; the data registers keep their last value
   // between loads so the ports see stable data when rvalid is low.
   always_comb begin
      rvalid0_d = grant0 && !we0;
      rvalid1_d = grant1 && !we1;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      if (grant0 && !we0) begin
         rdata0_d = mem_rd;
      end
      if (grant1 && !we1) begin
         rdata1_d = mem_rd;
      end
   end

   // All state registers; reset drops ownership, points the winner at port 1
   // so port 0 takes the first tie, and clears the load return registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         last_q    <= 1'b1;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   // A load that was in flight when reset arrives must not be reported, so
   // the registered valid is masked for the cycle reset is held.
   assign rvalid0 = rvalid0_q && !rst;
   assign rvalid1 = rvalid1_q && !rst;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed test of data_mem_arbiter against a small
// little-endian byte memory. Grant and memory-bus checks run in the stimulus
// process; returned load data is checked by a separate monitor from queues.
module tb_data_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MH = 4;

   // Per-port control nibble: {req, we, mode, lock}
   localparam logic [3:0] NONE = 4'b0000;
   localparam logic [3:0] LD   = 4'b1000;
   localparam logic [3:0] LDB  = 4'b1010;
   localparam logic [3:0] LDL  = 4'b1001;
   localparam logic [3:0] ST   = 4'b1100;
   localparam logic [3:0] STB  = 4'b1110;
   localparam logic [3:0] LKO  = 4'b0001;

   localparam logic [31:0] W20 = 32'h1122_3344;
   localparam logic [31:0] W40 = 32'h0403_0201;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, we0, mode0, lock0;
   logic          req1, we1, mode1, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          mem_we, mem_mode;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   logic [7:0]    mem_bytes [0:255];
   exp_t          q0[$];
   exp_t          q1[$];
   int            cyc = 0;
   int            tests_run = 0;
   int            failures = 0;

   data_mem_arbiter #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH   (DW),
      .MAX_HOLD     (MH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req0    (req0),
      .we0     (we0),
      .mode0   (mode0),
      .lock0   (lock0),
      .addr0   (addr0),
      .wdata0  (wdata0),
      .gnt0    (gnt0),
      .rvalid0 (rvalid0),
      .rdata0  (rdata0),
      .req1    (req1),
      .we1     (we1),
      .mode1   (mode1),
      .lock1   (lock1),
      .addr1   (addr1),
      .wdata1  (wdata1),
      .gnt1    (gnt1),
      .rvalid1 (rvalid1),
      .rdata1  (rdata1),
      .mem_we  (mem_we),
      .mem_mode(mem_mode),
      .mem_a   (mem_a),
      .mem_wd  (mem_wd),
      .mem_rd  (mem_rd)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp expected load returns.
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model read: byte mode returns the zero-extended byte, word mode
   // the little-endian word starting at the address.
   always_comb begin
      logic [7:0] idx;
      idx = mem_a[7:0];
      if (mem_mode) begin
         mem_rd = {24'h0, mem_bytes[idx]};
      end else begin
         mem_rd = {mem_bytes[idx + 8'd3], mem_bytes[idx + 8'd2],
                   mem_bytes[idx + 8'd1], mem_bytes[idx]};
      end
   end

   // Memory model write: commits at the edge that ends the grant cycle.
   always @(posedge clk) begin
      if (mem_we) begin
         if (mem_mode) begin
            mem_bytes[mem_a[7:0]] <= mem_wd[7:0];
         end else begin
            for (int b = 0; b < 4; b++) begin
               mem_bytes[mem_a[7:0] + 8'(b)] <= mem_wd[8*b +: 8];
            end
         end
      end
   end

   task automatic checkValue(input string name, input logic [65:0] act, input logic [65:0] exp);
      tests_run++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] d1);
      {req0, we0, mode0, lock0} = c0;
      addr0  = a0;
      wdata0 = d0;
      {req1, we1, mode1, lock1} = c1;
      addr1  = a1;
      wdata1 = d1;
   endtask

   // Checks grants and the memory bus against the bench's own expectation and
   // queues the expected load data for the monitor.
   task automatic checkOutput(input string name, input logic eg0, input logic eg1,
                              input logic push, input logic [31:0] edata);
      logic [65:0] exp_mem;
      exp_mem = '0;
      if (eg0) exp_mem = {we0, mode0, addr0, wdata0};
      else if (eg1) exp_mem = {we1, mode1, addr1, wdata1};
      checkValue({name, "_gnt"}, 66'({gnt1, gnt0}), 66'({eg1, eg0}));
      checkValue({name, "_mem"}, {mem_we, mem_mode, mem_a, mem_wd}, exp_mem);
      if (push) begin
         if (eg0) q0.push_back('{data: edata, due: cyc + 1});
         else if (eg1) q1.push_back('{data: edata, due: cyc + 1});
      end
   endtask

   task automatic runCycle(input string name, input logic eg0, input logic eg1,
                           input logic push, input logic [31:0] edata);
      @(negedge clk);
      checkOutput(name, eg0, eg1, push, edata);
      @(posedge clk);
      #1;
   endtask

   task automatic monitorPort(input int p, input logic rv, input logic [31:0] rd);
      exp_t e;
      logic have;
      have = 1'b0;
      if (p == 0) begin
         if (q0.size() > 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            have = 1'b1;
         end
      end else begin
         if (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            have = 1'b1;
         end
      end
      if (have) begin
         tests_run++;
         if (!rv || rd !== e.data || e.due != cyc) begin
            failures++;
            $display("[TB] FAIL load%0d_return: rvalid=%0b rdata=%h at cycle %0d, expected rvalid=1 rdata=%h at cycle %0d",
                     p, rv, rd, cyc, e.data, e.due);
         end
      end else if (rv) begin
         tests_run++;
         failures++;
         $display("[TB] FAIL load%0d_unexpected: rvalid=1 rdata=%h at cycle %0d, expected rvalid=0", p, rd, cyc);
      end
   endtask

   // Monitor: compares every returned load against the queued expectation.
   always @(negedge clk) begin
      monitorPort(0, rvalid0, rdata0);
      monitorPort(1, rvalid1, rdata1);
   end

   // Safety net so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence.
   initial begin
      rst = 1'b1;
      applyStimulus(NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0);
      @(posedge clk);
      #1;

      // Requests while reset is held must not reach the memory.
      applyStimulus(LD, 32'h20, 32'h0, LD, 32'h40, 32'h0);
      runCycle("reset_gate", 1'b0, 1'b0, 1'b0, 32'h0);
      checkValue("reset_rvalid", 66'({rvalid1, rvalid0}), 66'd0);
      checkValue("reset_rdata0", 66'(rdata0), 66'd0);
      checkValue("reset_rdata1", 66'(rdata1), 66'd0);
      rst = 1'b0;

      // Preload two words through the arbiter.
      applyStimulus(ST, 32'h20, W20, NONE, 32'h0, 32'h0);
      runCycle("preload0", 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(NONE, 32'h0, 32'h0, ST, 32'h40, W40);
      runCycle("preload1", 1'b0, 1'b1, 1'b0, 32'h0);

      rst = 1'b1;
      applyStimulus(NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("reset2", 1'b0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;

      // Round-robin ties between two load streams.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(LD, 32'h20, 32'h0, LD, 32'h40, 32'h0);
         runCycle("rr", (i % 2) == 0, (i % 2) == 1, 1'b1, ((i % 2) == 0) ? W20 : W40);
      end
      applyStimulus(NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("idle1", 1'b0, 1'b0, 1'b0, 32'h0);

      // Word store, byte loads, byte store, word loads, back-to-back loads.
      applyStimulus(ST, 32'h0001_0000, 32'hDEAD_BEEF, NONE, 32'h0, 32'h0);
      runCycle("st_word", 1'b1, 1'b0, 1'b0, 32'h0);
      applyStimulus(NONE, 32'h0, 32'h0, LDB, 32'h0001_0001, 32'h0);
      runCycle("ldb_be", 1'b0, 1'b1, 1'b1, 32'h0000_00BE);
      applyStimulus(LDB, 32'h0001_0003, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("ldb_de", 1'b1, 1'b0, 1'b1, 32'h0000_00DE);
      applyStimulus(NONE, 32'h0, 32'h0, STB, 32'h0001_0002, 32'hAAAA_BB77);
      runCycle("st_byte", 1'b0, 1'b1, 1'b0, 32'h0);
      applyStimulus(LD, 32'h0001_0000, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("ld_merged", 1'b1, 1'b0, 1'b1, 32'hDE77_BEEF);
      applyStimulus(NONE, 32'h0, 32'h0, LD, 32'h40, 32'h0);
      runCycle("ld1_word", 1'b0, 1'b1, 1'b1, W40);
      applyStimulus(LD, 32'h20, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("b2b_a", 1'b1, 1'b0, 1'b1, W20);
      applyStimulus(LD, 32'h0001_0000, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("b2b_b", 1'b1, 1'b0, 1'b1, 32'hDE77_BEEF);
      applyStimulus(NONE, 32'h0, 32'h0, LDB, 32'h40, 32'h0);
      runCycle("ldb1", 1'b0, 1'b1, 1'b1, 32'h0000_0001);
      applyStimulus(NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("idle2", 1'b0, 1'b0, 1'b0, 32'h0);
      checkValue("hold_rvalid0", 66'(rvalid0), 66'd0);
      checkValue("hold_rdata0", 66'(rdata0), 66'(32'hDE77_BEEF));

      // Lock held on a tie: port 0 owns for MAX_HOLD cycles, then port 1.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(LDL, 32'h20, 32'h0, LD, 32'h40, 32'h0);
         runCycle("hold_max", i < 4, i == 4, 1'b1, (i < 4) ? W20 : W40);
      end

      // Lock dropped after one owned cycle releases ownership early.
      applyStimulus(LDL, 32'h20, 32'h0, LD, 32'h40, 32'h0);
      runCycle("early_a", 1'b1, 1'b0, 1'b1, W20);
      applyStimulus(LD, 32'h20, 32'h0, LD, 32'h40, 32'h0);
      runCycle("early_b", 1'b1, 1'b0, 1'b1, W20);
      applyStimulus(LD, 32'h20, 32'h0, LD, 32'h40, 32'h0);
      runCycle("early_c", 1'b0, 1'b1, 1'b1, W40);

      // Port 1 owns with no request: port 0 stalls until the hold expires.
      applyStimulus(NONE, 32'h0, 32'h0, LDL, 32'h40, 32'h0);
      runCycle("own1_enter", 1'b0, 1'b1, 1'b1, W40);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(LD, 32'h20, 32'h0, LKO, 32'h40, 32'h0);
         runCycle("own1_stall", 1'b0, 1'b0, 1'b0, 32'h0);
      end
      applyStimulus(LD, 32'h20, 32'h0, LKO, 32'h40, 32'h0);
      runCycle("own1_release", 1'b1, 1'b0, 1'b1, W20);

      // Reset with a port-0 load in flight.
      applyStimulus(LD, 32'h20, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("inflight_ld", 1'b1, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      applyStimulus(LD, 32'h20, 32'h0, LD, 32'h40, 32'h0);
      @(negedge clk);
      checkOutput("rst_inflight", 1'b0, 1'b0, 1'b0, 32'h0);
      checkValue("rst_rvalid0", 66'(rvalid0), 66'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(LD, 32'h20, 32'h0, LD, 32'h40, 32'h0);
      runCycle("post_rst_tie", 1'b1, 1'b0, 1'b1, W20);

      // Reset while port 1 owns the memory.
      applyStimulus(NONE, 32'h0, 32'h0, LDL, 32'h40, 32'h0);
      runCycle("own1_again", 1'b0, 1'b1, 1'b0, 32'h0);
      rst = 1'b1;
      applyStimulus(LD, 32'h20, 32'h0, LKO, 32'h40, 32'h0);
      @(negedge clk);
      checkOutput("rst_own1", 1'b0, 1'b0, 1'b0, 32'h0);
      checkValue("rst_rvalid1", 66'(rvalid1), 66'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(LD, 32'h20, 32'h0, LKO, 32'h40, 32'h0);
      runCycle("own_dropped", 1'b1, 1'b0, 1'b1, W20);

      applyStimulus(NONE, 32'h0, 32'h0, NONE, 32'h0, 32'h0);
      runCycle("drain_a", 1'b0, 1'b0, 1'b0, 32'h0);
      runCycle("drain_b", 1'b0, 1'b0, 1'b0, 32'h0);
      checkValue("q0_drained", 66'(q0.size()), 66'd0);
      checkValue("q1_drained", 66'(q1.size()), 66'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
